// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: captures writeback commits into a FIFO and
// serialises each one into a 9- or 14-byte packet on a byte-wide valid/ready stream.
module retire_trace_tx #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trace_en,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_pc,
    input  logic [31:0]              commit_insn,
    input  logic                     commit_we,
    input  logic [4:0]               commit_rd,
    input  logic [31:0]              commit_wdata,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_last,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_PC    = 3'd2;
    localparam logic [2:0] S_INSN  = 3'd3;
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_WDATA = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        has_wb;
        logic [4:0]  seq;
        logic        lost;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [4:0]        seq_q, seq_d;
    logic              lost_q, lost_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [2:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    entry_t            cur_q, cur_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_last_q, tx_last_d;

    logic              capture;
    logic              full;
    logic              push;
    logic              drop;
    logic              pop;
    logic              hs;
    logic              last_hs;
    entry_t            entry_in;

    // Byte presented for a given serializer position.
    function automatic logic [7:0] sel_byte(input entry_t e, input logic [2:0] st,
                                            input logic [1:0] idx);
        logic [7:0] b;
        case (st)
            S_HDR:   b = {1'b1, e.has_wb, e.lost, e.seq};
            S_PC:    b = e.pc[{idx, 3'b000} +: 8];
            S_INSN:  b = e.insn[{idx, 3'b000} +: 8];
            S_RD:    b = {3'b000, e.rd};
            S_WDATA: b = e.wdata[{idx, 3'b000} +: 8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic is_last(input entry_t e, input logic [2:0] st,
                                     input logic [1:0] idx);
        return (idx == 2'd3) && ((st == S_INSN && !e.has_wb) || st == S_WDATA);
    endfunction

    // Capture side: fullness is judged on the pre-edge level, so a same-cycle pop never makes room.
    always_comb begin
        capture    = trace_en && commit_valid;
        full       = (level_q == LW'(DEPTH));
        push       = capture && !full;
        drop       = capture && full;

        entry_in.pc     = commit_pc;
        entry_in.insn   = commit_insn;
        entry_in.wdata  = commit_wdata;
        entry_in.rd     = commit_rd;
        entry_in.has_wb = commit_we && (commit_rd != 5'd0);
        entry_in.seq    = seq_q;
        entry_in.lost   = lost_q;

        seq_d      = seq_q;
        lost_d     = lost_q;
        drop_cnt_d = drop_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        if (push) begin
            seq_d    = seq_q + 5'd1;
            lost_d   = 1'b0;
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else if (drop) begin
            lost_d = 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end

        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    // Serializer next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_d      = cur_q;
        pop        = 1'b0;
        last_hs    = 1'b0;
        hs         = tx_valid_q && tx_ready;

        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop = 1'b1;
                end
            end
            S_HDR: begin
                if (hs) begin
                    state_d = S_PC;
                    idx_d   = 2'd0;
                end
            end
            S_PC: begin
                if (hs) begin
                    if (idx_q == 2'd3) begin
                        state_d = S_INSN;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_INSN: begin
                if (hs) begin
                    if (idx_q == 2'd3) begin
                        if (cur_q.has_wb) begin
                            state_d = S_RD;
                            idx_d   = 2'd0;
                        end else begin
                            last_hs = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_RD: begin
                if (hs) begin
                    state_d = S_WDATA;
                    idx_d   = 2'd0;
                end
            end
            S_WDATA: begin
                if (hs) begin
                    if (idx_q == 2'd3) begin
                        last_hs = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
        endcase

        // Chain straight into the next queued packet to avoid an idle gap.
        if (last_hs) begin
            if (level_q != '0) begin
                pop = 1'b1;
            end else begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
        end

        if (pop) begin
            cur_d   = mem_q[rd_ptr_q];
            state_d = S_HDR;
            idx_d   = 2'd0;
        end

        tx_valid_d = (state_d != S_IDLE);
        tx_data_d  = (state_d == S_IDLE) ? 8'h00 : sel_byte(cur_d, state_d, idx_d);
        tx_last_d  = (state_d != S_IDLE) && is_last(cur_d, state_d, idx_d);
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            lost_q     <= 1'b0;
            drop_cnt_q <= '0;
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            cur_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_last_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            lost_q     <= lost_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_q      <= cur_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign tx_last    = tx_last_q;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Self-checking bench for retire_trace_tx: directed scenarios plus a randomized
// run against a queue-based packet model.
`timescale 1ns/1ps
module tb_retire_trace_tx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_en = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_insn = '0;
    logic        commit_we = 1'b0;
    logic [4:0]  commit_rd = '0;
    logic [31:0] commit_wdata = '0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_ready = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       drop_cnt;

    int checks = 0;
    int errors = 0;

    retire_trace_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_insn(commit_insn), .commit_we(commit_we),
        .commit_rd(commit_rd), .commit_wdata(commit_wdata), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit [31:0] pc;
        bit [31:0] insn;
        bit [31:0] wdata;
        bit [4:0]  rd;
        bit        has_wb;
        bit [4:0]  seq;
        bit        lost;
    } ment_t;

    // Model: stored entries, bytes of the packet in flight, and the whole expected stream.
    ment_t    m_fifo[$];
    bit [8:0] m_out[$];
    bit [8:0] exp_q[$];
    bit [8:0] rx_q[$];
    int       m_seq;
    bit       m_lost;
    int       m_drop;

    always @(posedge clk) begin
        if (rst_n && tx_valid && tx_ready) rx_q.push_back({tx_last, tx_data});
    end

    function automatic void emit(input ment_t e, input bit to_out);
        bit [7:0] b[$];
        bit [8:0] v;
        b.push_back(8'(128 + (e.has_wb ? 64 : 0) + (e.lost ? 32 : 0) + int'(e.seq)));
        for (int i = 0; i < 4; i++) b.push_back(8'((e.pc >> (8 * i)) & 32'hFF));
        for (int i = 0; i < 4; i++) b.push_back(8'((e.insn >> (8 * i)) & 32'hFF));
        if (e.has_wb) begin
            b.push_back(8'(e.rd));
            for (int i = 0; i < 4; i++) b.push_back(8'((e.wdata >> (8 * i)) & 32'hFF));
        end
        for (int i = 0; i < b.size(); i++) begin
            v = {(i == b.size() - 1), b[i]};
            if (to_out) m_out.push_back(v);
            else exp_q.push_back(v);
        end
    endfunction

    // One clock: advance the model on the edge using pre-edge values, return at negedge.
    task automatic tick();
        bit cap;
        bit full;
        ment_t e;
        @(posedge clk);
        if (rst_n) begin
            cap  = trace_en && commit_valid;
            full = (m_fifo.size() == DEPTH);
            if (m_out.size() != 0) begin
                if (tx_ready) begin
                    void'(m_out.pop_front());
                    if (m_out.size() == 0 && m_fifo.size() != 0) begin
                        e = m_fifo.pop_front();
                        emit(e, 1'b1);
                    end
                end
            end else if (m_fifo.size() != 0) begin
                e = m_fifo.pop_front();
                emit(e, 1'b1);
            end
            if (cap) begin
                if (!full) begin
                    e.pc = commit_pc; e.insn = commit_insn; e.wdata = commit_wdata;
                    e.rd = commit_rd; e.has_wb = commit_we && (commit_rd != 0);
                    e.seq = 5'(m_seq); e.lost = m_lost;
                    m_fifo.push_back(e);
                    emit(e, 1'b0);
                    m_seq  = (m_seq + 1) % 32;
                    m_lost = 1'b0;
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_lost = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_commit(input bit [31:0] pc, input bit [31:0] insn, input bit we,
                              input bit [4:0] rd, input bit [31:0] wdata);
        commit_valid = 1'b1; commit_pc = pc; commit_insn = insn;
        commit_we = we; commit_rd = rd; commit_wdata = wdata;
    endtask

    task automatic clr_commit();
        commit_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_commit();
        m_fifo.delete(); m_out.delete(); exp_q.delete(); rx_q.delete();
        m_seq = 0; m_lost = 1'b0; m_drop = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        clr_commit();
        for (int i = 0; i < 300 && (tx_valid || m_out.size() != 0 || m_fifo.size() != 0); i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %02h want 00", tx_data); end
        checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last got %0b want 0", tx_last); end
        checks++; if (fifo_level !== 0) begin errors++; $display("FAIL reset_fifo_level got %0d want 0", fifo_level); end
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    endtask

    task automatic test_single();
        bit [7:0] ref_b[9];
        ref_b = '{8'h80, 8'h00, 8'h02, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        do_reset();
        tx_ready = 1'b1; trace_en = 1'b1;
        set_commit(32'h200, 32'h13, 1'b1, 5'd0, 32'h55);
        tick();
        clr_commit();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_lat_n1 got %0b want 0", tx_valid); end
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h80) begin
            errors++; $display("FAIL single_lat_n2 got v=%0b d=%02h want v=1 d=80", tx_valid, tx_data); end
        drain();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", tx_valid); end
        checks++; if (rx_q.size() != 9) begin errors++; $display("FAIL single_len got %0d want 9", rx_q.size()); end
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== {(i == 8), ref_b[i]}) begin
                errors++; $display("FAIL single_byte%0d got %03h want %03h", i, rx_q[i], {(i == 8), ref_b[i]}); end
        end
    endtask

    task automatic test_wb();
        bit [7:0] ref_b[14];
        ref_b = '{8'hC0, 8'h04, 8'h02, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00,
                  8'h01, 8'h0A, 8'h00, 8'h00, 8'h00};
        do_reset();
        tx_ready = 1'b1; trace_en = 1'b1;
        set_commit(32'h204, 32'h00A00093, 1'b1, 5'd1, 32'hA);
        tick();
        clr_commit();
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hC0) begin
            errors++; $display("FAIL wb_header got v=%0b d=%02h want v=1 d=c0", tx_valid, tx_data); end
        drain();
        checks++; if (rx_q.size() != 14) begin errors++; $display("FAIL wb_len got %0d want 14", rx_q.size()); end
        for (int i = 0; i < 14 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== {(i == 13), ref_b[i]}) begin
                errors++; $display("FAIL wb_byte%0d got %03h want %03h", i, rx_q[i], {(i == 13), ref_b[i]}); end
        end
    endtask

    task automatic test_backpressure();
        int base;
        tx_ready = 1'b1; trace_en = 1'b1;
        base = rx_q.size();
        set_commit($urandom, $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
        tick();
        clr_commit();
        for (int i = 0; i < 20 && (rx_q.size() - base) < 2; i++) tick();
        tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (m_out.size() == 0 || tx_valid !== 1'b1 || {tx_last, tx_data} !== m_out[0]) begin
                errors++; $display("FAIL bp_hold c%0d got v=%0b %03h want v=1 %03h", c, tx_valid,
                                   {tx_last, tx_data}, (m_out.size() != 0) ? m_out[0] : 9'h0); end
        end
        checks++; if (rx_q.size() - base != 2) begin errors++; $display("FAIL bp_stalled got %0d want 2", rx_q.size() - base); end
        drain();
        checks++; if (rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_byte%0d got %03h want %03h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tx_ready = 1'b0; trace_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_commit($urandom, $urandom, 1'b0, 5'($urandom), $urandom);
            tick();
        end
        clr_commit();
        checks++; if (fifo_level !== 4) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
        checks++; if (drop_cnt !== 1) begin errors++; $display("FAIL ovf_drop got %0d want 1", drop_cnt); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h80) begin
            errors++; $display("FAIL ovf_first_hdr got v=%0b d=%02h want v=1 d=80", tx_valid, tx_data); end
        // Capture on the last-byte handshake of packet 0: still full pre-edge, so dropped.
        tx_ready = 1'b1;
        repeat (8) tick();
        set_commit($urandom, $urandom, 1'b0, 5'd0, $urandom);
        tick();
        clr_commit();
        tx_ready = 1'b0;
        checks++; if (drop_cnt !== 2) begin errors++; $display("FAIL ovf_pop_drop got %0d want 2", drop_cnt); end
        checks++; if (fifo_level !== 3) begin errors++; $display("FAIL ovf_level_after_pop got %0d want 3", fifo_level); end
        set_commit($urandom, $urandom, 1'b0, 5'd0, $urandom);
        tick();
        clr_commit();
        checks++; if (fifo_level !== 4) begin errors++; $display("FAIL ovf_refill got %0d want 4", fifo_level); end
        drain();
        checks++; if (rx_q.size() != 54) begin errors++; $display("FAIL ovf_len got %0d want 54", rx_q.size()); end
        if (rx_q.size() >= 9) begin
            checks++; if (rx_q[rx_q.size() - 9] !== 9'h0A5) begin
                errors++; $display("FAIL ovf_lost_hdr got %03h want 0a5", rx_q[rx_q.size() - 9]); end
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL ovf_byte%0d got %03h want %03h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tx_ready = 1'b1; trace_en = 1'b1;
        for (int cyc = 0; cyc <= 28; cyc++) begin
            if (cyc < 3) set_commit($urandom, $urandom, 1'b0, 5'($urandom), $urandom);
            else clr_commit();
            tick();
            if (cyc == 0 || cyc == 28) begin
                checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_edge c%0d got %0b want 0", cyc, tx_valid); end
            end else begin
                checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap c%0d got %0b want 1", cyc, tx_valid); end
            end
        end
        checks++; if (rx_q.size() != 27) begin errors++; $display("FAIL b2b_len got %0d want 27", rx_q.size()); end
        for (int p = 0; p < 3 && rx_q.size() >= 27; p++) begin
            checks++; if (rx_q[p * 9] !== 9'(8'h80 + p)) begin
                errors++; $display("FAIL b2b_hdr%0d got %03h want %03h", p, rx_q[p * 9], 9'(8'h80 + p)); end
            checks++; if (rx_q[p * 9 + 8][8] !== 1'b1) begin errors++; $display("FAIL b2b_last%0d got 0 want 1", p); end
        end
    endtask

    task automatic test_trace_en_and_reset();
        tx_ready = 1'b1; trace_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_commit($urandom, $urandom, 1'b1, 5'd3, $urandom);
            tick();
        end
        clr_commit();
        repeat (3) begin
            tick();
            checks++; if (tx_valid !== 1'b0 || fifo_level !== 0) begin
                errors++; $display("FAIL en_off got v=%0b lvl=%0d want v=0 lvl=0", tx_valid, fifo_level); end
        end
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL en_off_drop got %0d want 0", drop_cnt); end
        trace_en = 1'b1;
        set_commit($urandom, $urandom, 1'b0, 5'd0, $urandom);
        tick();
        clr_commit();
        tx_ready = 1'b0;
        set_commit($urandom, $urandom, 1'b1, 5'd7, $urandom);
        tick();
        tick();
        clr_commit();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h83) begin
            errors++; $display("FAIL en_seq_hold got v=%0b d=%02h want v=1 d=83", tx_valid, tx_data); end
        tx_ready = 1'b1;
        tick();
        checks++; if (fifo_level !== 2) begin errors++; $display("FAIL pre_rst_level got %0d want 2", fifo_level); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", tx_valid); end
        checks++; if (fifo_level !== 0) begin errors++; $display("FAIL rst_mid_level got %0d want 0", fifo_level); end
        checks++; if (tx_last !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL rst_mid_data got %0b/%02h want 0/00", tx_last, tx_data); end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            trace_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) != 0)
                set_commit($urandom, $urandom, 1'($urandom), 5'($urandom), $urandom);
            else clr_commit();
            tx_ready = ((cyc / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            tick();
            checks++; if (fifo_level !== m_fifo.size() || drop_cnt !== m_drop) begin
                errors++; $display("FAIL rnd_state c%0d got lvl=%0d drop=%0d want lvl=%0d drop=%0d",
                                   cyc, fifo_level, drop_cnt, m_fifo.size(), m_drop); end
            checks++; if (tx_valid !== (m_out.size() != 0) ||
                          (m_out.size() != 0 && {tx_last, tx_data} !== m_out[0])) begin
                errors++; $display("FAIL rnd_out c%0d got v=%0b %03h want v=%0b %03h", cyc, tx_valid,
                                   {tx_last, tx_data}, (m_out.size() != 0), (m_out.size() != 0) ? m_out[0] : 9'h0); end
        end
        drain();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain got %0b want 0", tx_valid); end
        checks++; if (rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rnd_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rnd_byte%0d got %03h want %03h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_wb();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_trace_en_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
